noc_output_switch: RTL and testbench
====================================

NOC_OUTPUT_SWITCH -- requirements
Module: noc_output_switch

Interface
REQ-001 SHALL have parameter PORTS, default 5, number of input ports (2..8).
REQ-002 SHALL have parameter CHANNELS, default 2, number of virtual channels (1..4).
REQ-003 SHALL have parameter DATA_WIDTH, default 64, flit payload width.
REQ-004 SHALL have parameter DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-005 SHALL have port noc_clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port noc_rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid  input  PORTS*CHANNELS  per-port one-hot VC valid; port p uses bits [p*CHANNELS +: CHANNELS].
REQ-008 SHALL have port in_flit  input  PORTS*DATA_WIDTH  per-port flit payload.
REQ-009 SHALL have port in_head  input  PORTS  per-port head-flit marker.
REQ-010 SHALL have port in_tail  input  PORTS  per-port tail-flit marker (head+tail = single-flit packet).
REQ-011 SHALL have port in_ready  output  PORTS  per-port accept; transfer when any in_valid bit of port AND in_ready.
REQ-012 SHALL have port out_valid  output  CHANNELS  one-hot VC of FIFO head entry; zero when empty.
REQ-013 SHALL have port out_flit / out_head / out_tail  output  DATA_WIDTH/1/1  FIFO head entry fields.
REQ-014 SHALL have port out_vc_ready  input  CHANNELS  downstream per-VC accept.
REQ-015 SHALL have port grant  output  PORTS  one-hot port currently granted; zero when none.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1)  FIFO occupancy.

Function
REQ-017 SHALL implement FSM states IDLE and LOCKED with registers owner (port index) and rr_ptr (round-robin start index).
REQ-018 In IDLE, grant SHALL go to the first port, searching from rr_ptr upward with wrap at PORTS, having any in_valid bit and in_head=1; non-head flits in IDLE SHALL be ignored (not granted).
REQ-019 In LOCKED, grant SHALL be the owner port only, regardless of other requests.
REQ-020 in_ready SHALL equal grant AND NOT full; at most one bit set per cycle; combinational from state, in_valid, in_head and full.
REQ-021 Accepting a head without tail SHALL move IDLE->LOCKED with owner = granted port.
REQ-022 Accepting a tail (LOCKED, or head+tail in IDLE) SHALL set state IDLE and rr_ptr = (port+1) mod PORTS.
REQ-023 rr_ptr SHALL not change on any other event; a stalled head (full FIFO) SHALL keep its grant next cycle unless a higher-priority port appears (IDLE re-arbitrates each cycle).
REQ-024 Multi-hot in_valid within a port SHALL be reduced to its lowest set bit; stored VC is that bit.
REQ-025 FIFO SHALL store {vc, head, tail, flit} per accepted flit; push on transfer, pop when (out_valid & out_vc_ready) != 0.
REQ-026 Latency: accepted flit SHALL appear on outputs no earlier than the next cycle (no fall-through).
REQ-027 Full (count=DEPTH) SHALL deassert all in_ready even if a pop occurs the same cycle; simultaneous push and pop when not full SHALL keep count unchanged.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-029 Output head entry SHALL be blocked only by its own VC's out_vc_ready (in-order, head-of-line blocking accepted).

Reset
REQ-030 With noc_rst_n=0 at a clock edge: state IDLE, owner 0, rr_ptr 0, FIFO empty, count 0.
REQ-031 During and after reset until inputs request: out_valid=0, out_head=0, out_tail=0, out_flit=0, grant=0, in_ready=0.
REQ-032 Reset mid-packet SHALL drop the lock and discard all buffered flits; no partial packet SHALL be emitted after reset.

Verification
REQ-033 Ports 0,2 present head+tail on VC0 simultaneously, rr_ptr=0, out_vc_ready=all 1 -> port 0 accepted cycle 0, port 2 cycle 1, out_valid=01 in cycles 1 and 2 in that order.
REQ-034 Port 1 sends 3-flit packet (head, body, tail) while port 3 holds a head valid -> grant stays 0b00010 for 3 transfers; port 3 granted next cycle; rr_ptr=2 after tail.
REQ-035 out_vc_ready=0, DEPTH=4, port 0 streams 6 flits -> 4 accepted, count=4, in_ready=0; raise out_vc_ready -> one pop per cycle, in_ready reasserts the cycle after count<4.
REQ-036 Head entry on VC1 with out_vc_ready=01 -> out_valid=10 held, no pop, count constant; out_vc_ready=10 -> pop next edge.
REQ-037 Assert noc_rst_n=0 for 1 cycle after body flit of a locked packet -> next cycle count=0, grant=0, out_valid=0; new head on any port accepted by rr order from port 0.
REQ-038 Port 4 body flit (in_head=0) in IDLE -> in_ready=0, no push; PORTS=5 wrap: rr_ptr=4 with ports 0,4 heads -> port 4 granted first.

Source files
------------

// File: rtl/noc_output_switch.sv
// Output-port switch for a NoC router: wormhole arbitration across input ports
// into a single output FIFO, with per-VC downstream flow control.
module noc_output_switch #(
  parameter int PORTS      = 5,
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                          noc_clk,
  input  logic                          noc_rst_n,
  input  logic [PORTS*CHANNELS-1:0]     in_valid,
  input  logic [PORTS*DATA_WIDTH-1:0]   in_flit,
  input  logic [PORTS-1:0]              in_head,
  input  logic [PORTS-1:0]              in_tail,
  output logic [PORTS-1:0]              in_ready,
  output logic [CHANNELS-1:0]           out_valid,
  output logic [DATA_WIDTH-1:0]         out_flit,
  output logic                          out_head,
  output logic                          out_tail,
  input  logic [CHANNELS-1:0]           out_vc_ready,
  output logic [PORTS-1:0]              grant,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int PW    = $clog2(PORTS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                r_state;
  logic [PW-1:0]         r_owner;
  logic [PW-1:0]         r_rr_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CHANNELS-1:0]   r_mem_vc   [DEPTH];
  logic                  r_mem_head [DEPTH];
  logic                  r_mem_tail [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_flit [DEPTH];

  logic [PORTS-1:0]      w_port_req;
  logic [PW-1:0]         w_sel;
  logic                  w_any;
  logic [PW:0]           w_idx;
  logic [PORTS-1:0]      w_grant;
  logic                  w_full;
  logic                  w_empty;
  logic [CHANNELS-1:0]   w_sel_valid;
  logic [CHANNELS-1:0]   w_vc;
  logic [DATA_WIDTH-1:0] w_sel_flit;
  logic                  w_sel_head;
  logic                  w_sel_tail;
  logic                  w_push;
  logic                  w_pop;
  logic [PW-1:0]         w_rr_next;

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      w_port_req[p] = |in_valid[p*CHANNELS +: CHANNELS];
    end
  end

  // IDLE re-arbitrates every cycle among head flits starting at r_rr_ptr;
  // LOCKED pins the grant to the owner until its tail goes through.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    w_idx = '0;
    if (r_state == LOCKED) begin
      w_sel = r_owner;
      w_any = 1'b1;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        w_idx = {1'b0, r_rr_ptr} + (PW+1)'(i);
        if (w_idx >= (PW+1)'(PORTS)) w_idx = w_idx - (PW+1)'(PORTS);
        if (!w_any && w_port_req[w_idx[PW-1:0]] && in_head[w_idx[PW-1:0]]) begin
          w_any = 1'b1;
          w_sel = w_idx[PW-1:0];
        end
      end
    end
  end

  assign w_grant     = w_any ? (PORTS'(1) << w_sel) : '0;
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_sel_valid = in_valid[w_sel*CHANNELS +: CHANNELS];
  assign w_vc        = w_sel_valid & (~w_sel_valid + CHANNELS'(1));
  assign w_sel_flit  = in_flit[w_sel*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_head  = in_head[w_sel];
  assign w_sel_tail  = in_tail[w_sel];
  assign w_push      = w_any && !w_full && (|w_sel_valid);
  assign w_rr_next   = (w_sel == PW'(PORTS-1)) ? '0 : w_sel + PW'(1);

  assign grant    = w_grant;
  assign in_ready = w_full ? '0 : w_grant;

  // Outputs are forced to zero when empty so stale storage never leaks out.
  assign out_valid = w_empty ? '0 : r_mem_vc[r_rd_ptr];
  assign out_flit  = w_empty ? '0 : r_mem_flit[r_rd_ptr];
  assign out_head  = !w_empty && r_mem_head[r_rd_ptr];
  assign out_tail  = !w_empty && r_mem_tail[r_rd_ptr];
  assign w_pop     = |(out_valid & out_vc_ready);
  assign count     = r_count;

  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else if (w_push) begin
      if (w_sel_tail) begin
        r_state  <= IDLE;
        r_rr_ptr <= w_rr_next;
      end else if (r_state == IDLE && w_sel_head) begin
        r_state <= LOCKED;
        r_owner <= w_sel;
      end
    end
  end

  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge noc_clk) begin
    if (w_push) begin
      r_mem_vc[r_wr_ptr]   <= w_vc;
      r_mem_head[r_wr_ptr] <= w_sel_head;
      r_mem_tail[r_wr_ptr] <= w_sel_tail;
      r_mem_flit[r_wr_ptr] <= w_sel_flit;
    end
  end

endmodule

// File: tb/tb_noc_output_switch.sv
// Directed bench for noc_output_switch: arbitration, wormhole lock, FIFO full/VC blocking, reset.
module tb_noc_output_switch;
  localparam int P = 5;
  localparam int C = 2;
  localparam int W = 64;
  localparam int D = 4;

  logic           noc_clk;
  logic           noc_rst_n;
  logic [P*C-1:0] in_valid;
  logic [P*W-1:0] in_flit;
  logic [P-1:0]   in_head;
  logic [P-1:0]   in_tail;
  logic [P-1:0]   in_ready;
  logic [C-1:0]   out_valid;
  logic [W-1:0]   out_flit;
  logic           out_head;
  logic           out_tail;
  logic [C-1:0]   out_vc_ready;
  logic [P-1:0]   grant;
  logic [2:0]     count;

  int n_pass  = 0;
  int n_total = 0;

  noc_output_switch #(.PORTS(P), .CHANNELS(C), .DATA_WIDTH(W), .DEPTH(D)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .in_valid(in_valid), .in_flit(in_flit), .in_head(in_head), .in_tail(in_tail),
    .in_ready(in_ready), .out_valid(out_valid), .out_flit(out_flit),
    .out_head(out_head), .out_tail(out_tail), .out_vc_ready(out_vc_ready),
    .grant(grant), .count(count)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  task automatic tick;
    @(posedge noc_clk);
    #1;
  endtask

  task automatic clear_inputs;
    in_valid = '0;
    in_flit  = '0;
    in_head  = '0;
    in_tail  = '0;
  endtask

  task automatic set_port(input int p, input logic [C-1:0] vc, input logic [W-1:0] f,
                          input logic h, input logic t);
    in_valid[p*C +: C] = vc;
    in_flit[p*W +: W]  = f;
    in_head[p]         = h;
    in_tail[p]         = t;
  endtask

  task automatic do_reset;
    clear_inputs();
    noc_rst_n = 1'b0;
    tick();
    noc_rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    clear_inputs();
    out_vc_ready = '1;
    noc_rst_n = 1'b0;
    tick();
    tick();
    n_total++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_total++; if (grant !== 5'b0) $display("FAIL reset_grant got=%b exp=00000", grant); else n_pass++;
    n_total++; if (in_ready !== 5'b0) $display("FAIL reset_in_ready got=%b exp=00000", in_ready); else n_pass++;
    n_total++; if (out_valid !== 2'b0) $display("FAIL reset_out_valid got=%b exp=00", out_valid); else n_pass++;
    n_total++; if ({out_flit, out_head, out_tail} !== 66'b0) $display("FAIL reset_out_fields flit=%h h=%b t=%b exp=0", out_flit, out_head, out_tail); else n_pass++;
    noc_rst_n = 1'b1;
    tick();
    n_total++; if (grant !== 5'b0 || out_valid !== 2'b0) $display("FAIL post_reset_idle grant=%b out_valid=%b exp=0", grant, out_valid); else n_pass++;
  endtask

  task automatic test_rr_pair;
    do_reset();
    out_vc_ready = 2'b11;
    set_port(0, 2'b01, 64'hA0, 1'b1, 1'b1);
    set_port(2, 2'b01, 64'hA2, 1'b1, 1'b1);
    #1;
    n_total++; if (grant !== 5'b00001) $display("FAIL rr_grant_c0 got=%b exp=00001", grant); else n_pass++;
    n_total++; if (in_ready !== 5'b00001) $display("FAIL rr_ready_c0 got=%b exp=00001", in_ready); else n_pass++;
    n_total++; if (out_valid !== 2'b00) $display("FAIL rr_no_fallthrough got=%b exp=00", out_valid); else n_pass++;
    tick();
    set_port(0, 2'b00, 64'h0, 1'b0, 1'b0);
    #1;
    n_total++; if (grant !== 5'b00100) $display("FAIL rr_grant_c1 got=%b exp=00100", grant); else n_pass++;
    n_total++; if (out_valid !== 2'b01 || out_flit !== 64'hA0) $display("FAIL rr_out_c1 valid=%b flit=%h exp=01/a0", out_valid, out_flit); else n_pass++;
    n_total++; if ({out_head, out_tail} !== 2'b11) $display("FAIL rr_ht_c1 got=%b exp=11", {out_head, out_tail}); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_total++; if (out_valid !== 2'b01 || out_flit !== 64'hA2) $display("FAIL rr_out_c2 valid=%b flit=%h exp=01/a2", out_valid, out_flit); else n_pass++;
    n_total++; if (count !== 3'd1 || grant !== 5'b0) $display("FAIL rr_c2_state count=%0d grant=%b exp=1/00000", count, grant); else n_pass++;
    tick();
    n_total++; if (count !== 3'd0 || out_valid !== 2'b00) $display("FAIL rr_drain count=%0d valid=%b exp=0/00", count, out_valid); else n_pass++;
  endtask

  task automatic test_locked;
    do_reset();
    out_vc_ready = 2'b11;
    set_port(1, 2'b10, 64'h11, 1'b1, 1'b0);
    set_port(3, 2'b01, 64'h33, 1'b1, 1'b1);
    #1;
    n_total++; if (grant !== 5'b00010) $display("FAIL lock_grant_head got=%b exp=00010", grant); else n_pass++;
    tick();
    set_port(1, 2'b10, 64'h12, 1'b0, 1'b0);
    #1;
    n_total++; if (grant !== 5'b00010) $display("FAIL lock_grant_body got=%b exp=00010", grant); else n_pass++;
    n_total++; if (out_valid !== 2'b10 || {out_head, out_tail} !== 2'b10) $display("FAIL lock_out_head valid=%b ht=%b exp=10/10", out_valid, {out_head, out_tail}); else n_pass++;
    tick();
    set_port(1, 2'b10, 64'h13, 1'b0, 1'b1);
    #1;
    n_total++; if (grant !== 5'b00010) $display("FAIL lock_grant_tail got=%b exp=00010", grant); else n_pass++;
    n_total++; if (out_flit !== 64'h12) $display("FAIL lock_out_body got=%h exp=12", out_flit); else n_pass++;
    tick();
    set_port(1, 2'b00, 64'h0, 1'b0, 1'b0);
    set_port(0, 2'b01, 64'h30, 1'b1, 1'b1);
    #1;
    n_total++; if (grant !== 5'b01000) $display("FAIL lock_release_grant got=%b exp=01000", grant); else n_pass++;
    n_total++; if (out_flit !== 64'h13 || out_tail !== 1'b1) $display("FAIL lock_out_tail flit=%h t=%b exp=13/1", out_flit, out_tail); else n_pass++;
    tick();
    set_port(3, 2'b00, 64'h0, 1'b0, 1'b0);
    #1;
    n_total++; if (grant !== 5'b00001) $display("FAIL lock_rr_wrap got=%b exp=00001", grant); else n_pass++;
    n_total++; if (out_flit !== 64'h33 || out_valid !== 2'b01) $display("FAIL lock_out_p3 flit=%h valid=%b exp=33/01", out_flit, out_valid); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_total++; if (out_flit !== 64'h30) $display("FAIL lock_out_p0 got=%h exp=30", out_flit); else n_pass++;
    tick();
    n_total++; if (count !== 3'd0) $display("FAIL lock_drain got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_full;
    logic [W-1:0] exp_f;
    do_reset();
    out_vc_ready = 2'b00;
    set_port(0, 2'b01, 64'd100, 1'b1, 1'b1);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (in_ready !== 5'b00001) $display("FAIL full_fill_ready%0d got=%b exp=00001", i, in_ready); else n_pass++;
      tick();
      set_port(0, 2'b01, 64'd101 + 64'(i), 1'b1, 1'b1);
      #1;
    end
    n_total++; if (count !== 3'd4) $display("FAIL full_count got=%0d exp=4", count); else n_pass++;
    n_total++; if (in_ready !== 5'b0 || grant !== 5'b00001) $display("FAIL full_stall ready=%b grant=%b exp=00000/00001", in_ready, grant); else n_pass++;
    tick();
    n_total++; if (count !== 3'd4 || in_ready !== 5'b0) $display("FAIL full_hold count=%0d ready=%b exp=4/00000", count, in_ready); else n_pass++;
    out_vc_ready = 2'b11;
    #1;
    n_total++; if (in_ready !== 5'b0) $display("FAIL full_pop_same_cycle got=%b exp=00000", in_ready); else n_pass++;
    n_total++; if (out_flit !== 64'd100) $display("FAIL full_out0 got=%0d exp=100", out_flit); else n_pass++;
    tick();
    n_total++; if (count !== 3'd3 || in_ready !== 5'b00001) $display("FAIL full_reassert count=%0d ready=%b exp=3/00001", count, in_ready); else n_pass++;
    tick();
    set_port(0, 2'b01, 64'd105, 1'b1, 1'b1);
    #1;
    n_total++; if (count !== 3'd3) $display("FAIL full_push_pop got=%0d exp=3", count); else n_pass++;
    tick();
    clear_inputs();
    #1;
    exp_f = 64'd103;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (out_flit !== exp_f || count !== 3'(3 - i)) $display("FAIL full_drain%0d flit=%0d count=%0d exp=%0d/%0d", i, out_flit, count, exp_f, 3 - i); else n_pass++;
      exp_f = exp_f + 64'd1;
      tick();
    end
    n_total++; if (count !== 3'd0 || out_valid !== 2'b00) $display("FAIL full_empty count=%0d valid=%b exp=0/00", count, out_valid); else n_pass++;
  endtask

  task automatic test_vc_block;
    do_reset();
    out_vc_ready = 2'b01;
    set_port(0, 2'b10, 64'hC0, 1'b1, 1'b1);
    tick();
    clear_inputs();
    #1;
    n_total++; if (out_valid !== 2'b10 || count !== 3'd1) $display("FAIL vc_block0 valid=%b count=%0d exp=10/1", out_valid, count); else n_pass++;
    tick();
    n_total++; if (out_valid !== 2'b10 || count !== 3'd1 || out_flit !== 64'hC0) $display("FAIL vc_block1 valid=%b count=%0d flit=%h exp=10/1/c0", out_valid, count, out_flit); else n_pass++;
    out_vc_ready = 2'b10;
    tick();
    n_total++; if (count !== 3'd0 || out_valid !== 2'b00) $display("FAIL vc_unblock count=%0d valid=%b exp=0/00", count, out_valid); else n_pass++;
    out_vc_ready = 2'b00;
    set_port(2, 2'b11, 64'hC2, 1'b1, 1'b1);
    tick();
    clear_inputs();
    #1;
    n_total++; if (out_valid !== 2'b01) $display("FAIL vc_multihot got=%b exp=01", out_valid); else n_pass++;
    out_vc_ready = 2'b11;
    tick();
    n_total++; if (count !== 3'd0) $display("FAIL vc_multihot_pop got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_reset_midpacket;
    do_reset();
    out_vc_ready = 2'b00;
    set_port(3, 2'b01, 64'hD0, 1'b1, 1'b0);
    #1;
    n_total++; if (grant !== 5'b01000) $display("FAIL mid_head_grant got=%b exp=01000", grant); else n_pass++;
    tick();
    set_port(3, 2'b01, 64'hD1, 1'b0, 1'b0);
    #1;
    n_total++; if (grant !== 5'b01000) $display("FAIL mid_body_grant got=%b exp=01000", grant); else n_pass++;
    tick();
    n_total++; if (count !== 3'd2) $display("FAIL mid_count got=%0d exp=2", count); else n_pass++;
    clear_inputs();
    noc_rst_n = 1'b0;
    tick();
    noc_rst_n = 1'b1;
    #1;
    n_total++; if (count !== 3'd0 || grant !== 5'b0 || out_valid !== 2'b0) $display("FAIL mid_reset count=%0d grant=%b valid=%b exp=0/0/0", count, grant, out_valid); else n_pass++;
    set_port(1, 2'b01, 64'hE1, 1'b1, 1'b1);
    set_port(3, 2'b01, 64'hE3, 1'b1, 1'b1);
    #1;
    n_total++; if (grant !== 5'b00010) $display("FAIL mid_new_grant got=%b exp=00010", grant); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_total++; if (count !== 3'd1 || out_flit !== 64'hE1 || out_valid !== 2'b01) $display("FAIL mid_new_out count=%0d flit=%h valid=%b exp=1/e1/01", count, out_flit, out_valid); else n_pass++;
  endtask

  task automatic test_idle_body_wrap;
    do_reset();
    out_vc_ready = 2'b11;
    set_port(4, 2'b01, 64'hB4, 1'b0, 1'b0);
    #1;
    n_total++; if (in_ready !== 5'b0 || grant !== 5'b0) $display("FAIL idle_body ready=%b grant=%b exp=00000/00000", in_ready, grant); else n_pass++;
    tick();
    n_total++; if (count !== 3'd0) $display("FAIL idle_body_nopush got=%0d exp=0", count); else n_pass++;
    clear_inputs();
    set_port(3, 2'b01, 64'h33, 1'b1, 1'b1);
    #1;
    n_total++; if (grant !== 5'b01000) $display("FAIL wrap_setup got=%b exp=01000", grant); else n_pass++;
    tick();
    clear_inputs();
    set_port(0, 2'b01, 64'h40, 1'b1, 1'b1);
    set_port(4, 2'b01, 64'h44, 1'b1, 1'b1);
    #1;
    n_total++; if (grant !== 5'b10000) $display("FAIL wrap_p4_first got=%b exp=10000", grant); else n_pass++;
    tick();
    set_port(4, 2'b00, 64'h0, 1'b0, 1'b0);
    #1;
    n_total++; if (grant !== 5'b00001 || out_flit !== 64'h44) $display("FAIL wrap_p0_next grant=%b flit=%h exp=00001/44", grant, out_flit); else n_pass++;
    tick();
    clear_inputs();
    tick();
    n_total++; if (count !== 3'd0) $display("FAIL wrap_drain got=%0d exp=0", count); else n_pass++;
  endtask

  initial begin
    clear_inputs();
    out_vc_ready = '0;
    noc_rst_n = 1'b0;
    test_reset();
    test_rr_pair();
    test_locked();
    test_full();
    test_vc_block();
    test_reset_midpacket();
    test_idle_body_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
